// File: rtl/ifm_pkg.sv
// ifm_pkg: shared write-FSM states and default chunk length for the IFM ping-pong controller
package ifm_pkg;
  typedef enum logic {FILL, WAIT} wr_state_e;
  localparam int WR_BEAT_NUM_DEF = 4;
endpackage

// File: rtl/ifm_pingpong_ctrl_if.sv
// ifm_pingpong_ctrl_if: upstream beat handshake, buffer write strobe and read-bank handshake
interface ifm_pingpong_ctrl_if import ifm_pkg::*; #(
  parameter int WR_BEAT_NUM = WR_BEAT_NUM_DEF
);
  localparam int CW = $clog2(WR_BEAT_NUM);
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          wr_valid_o;
  logic [CW-1:0] wr_count_o;
  logic          wr_sel_o;
  logic          rd_sel_o;
  logic          rd_chunk_vld_o;
  logic          rd_done_i;
  modport slave (
    input  flush_i, in_valid_i, rd_done_i,
    output in_ready_o, wr_valid_o, wr_count_o, wr_sel_o, rd_sel_o, rd_chunk_vld_o
  );
  modport master (
    output flush_i, in_valid_i, rd_done_i,
    input  in_ready_o, wr_valid_o, wr_count_o, wr_sel_o, rd_sel_o, rd_chunk_vld_o
  );
endinterface

// File: rtl/ifm_sat_cnt.sv
// ifm_sat_cnt: saturating event counter with synchronous clear (built only with IFM_STALL_CNT_EN)
`ifdef IFM_STALL_CNT_EN
module ifm_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  // count events, holding at all-ones; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_o <= '0;
    else if (clr_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + W'(1);
endmodule
`endif

// File: rtl/ifm_pingpong_ctrl.sv
// ifm_pingpong_ctrl: two-bank ping-pong IFM buffer controller; IFM_STALL_CNT_EN adds stall/starve counters
module ifm_pingpong_ctrl import ifm_pkg::*; #(
  parameter int WR_BEAT_NUM = WR_BEAT_NUM_DEF,
  parameter int CNT_W       = 16
) (
  input logic clk_i,
  input logic rst_i,
  ifm_pingpong_ctrl_if.slave bus
`ifdef IFM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] wr_stall_cnt_o,
  output logic [CNT_W-1:0] rd_starve_cnt_o
`endif
);
  localparam int CW = $clog2(WR_BEAT_NUM);
  if (WR_BEAT_NUM < 2 || WR_BEAT_NUM > 256 || CNT_W < 1) begin : g_bad_param
    $error("ifm_pingpong_ctrl: WR_BEAT_NUM must be 2..256 and CNT_W at least 1");
  end
  logic [1:0]    full_q, full_d, set_v, clr_v;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, last, rel;
  wr_state_e     state_q, state_d;
  assign bus.in_ready_o     = (state_q == FILL) && !bus.flush_i;
  assign bus.wr_valid_o     = bus.in_valid_i && bus.in_ready_o;
  assign bus.wr_count_o     = cnt_q;
  assign bus.wr_sel_o       = wr_sel_q;
  assign bus.rd_sel_o       = rd_sel_q;
  assign bus.rd_chunk_vld_o = full_q[rd_sel_q];
  assign last  = bus.wr_valid_o && cnt_q == CW'(WR_BEAT_NUM - 1);
  assign rel   = bus.rd_done_i && full_q[rd_sel_q];
  assign set_v = {2{last}} & {wr_sel_q, !wr_sel_q};
  assign clr_v = {2{rel}} & {rd_sel_q, !rd_sel_q};
  // bank flags, pointers and beat counter advance; flush overrides every event, WAIT tracks a full write bank
  always_comb begin
    full_d   = bus.flush_i ? 2'b00 : (full_q | set_v) & ~clr_v;
    cnt_d    = (bus.flush_i || last) ? '0 : cnt_q + CW'(bus.wr_valid_o);
    wr_sel_d = !bus.flush_i && (wr_sel_q ^ last);
    rd_sel_d = !bus.flush_i && (rd_sel_q ^ rel);
    state_d  = full_d[wr_sel_d] ? WAIT : FILL;
  end
  // state register; reset discards any partial chunk
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      full_q   <= 2'b00;
      cnt_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      state_q  <= FILL;
    end else begin
      full_q   <= full_d;
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      state_q  <= state_d;
    end
  a_no_set_clr: assert property (@(posedge clk_i) disable iff (!rst_i) !(|(set_v & clr_v)));
  a_wait_full:  assert property (@(posedge clk_i) disable iff (!rst_i) (state_q == WAIT) == full_q[wr_sel_q]);
`ifdef IFM_STALL_CNT_EN
  logic started_q;
  // remember that a chunk has completed so read starvation is only counted afterwards
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) started_q <= 1'b0;
    else started_q <= !bus.flush_i && (started_q || last);
  ifm_sat_cnt #(.W(CNT_W)) u_wr_stall (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.flush_i),
    .inc_i (bus.in_valid_i && !bus.in_ready_o),
    .cnt_o (wr_stall_cnt_o)
  );
  ifm_sat_cnt #(.W(CNT_W)) u_rd_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.flush_i),
    .inc_i (started_q && !full_q[rd_sel_q]),
    .cnt_o (rd_starve_cnt_o)
  );
`endif
endmodule
